// File: rtl/uart_receive.sv
// uart_receive: one-bit-per-clock UART receiver (start, D_WIDTH data LSB first, stop).
// Deserialises rx and presents bytes on a valid/ready output with framing-error
// and overrun pulses. Define UART_R_FIFO_EN to replace the single holding
// register with a FIFO_DEPTH-entry FIFO.
module uart_receive #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned C_WIDTH    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ready,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               frame_err,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STOP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam logic [C_WIDTH-1:0] LAST_BIT = C_WIDTH'(D_WIDTH - 1);

  state_t               r_state;
  logic [C_WIDTH-1:0]   r_cnt;
  logic [D_WIDTH-1:0]   r_shift;
  logic                 r_busy;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_push;
  logic                 w_pop;

  // A completed byte is handed to storage on the edge that samples a good stop bit
  assign w_push = (r_state == S_STOP) && rx;

  // Frame state machine: start detect, data shift, stop check, break wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!rx) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DATA: begin
          r_shift <= {rx, r_shift[D_WIDTH-1:1]};
          r_cnt   <= r_cnt + C_WIDTH'(1);
          if (r_cnt == LAST_BIT) begin
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_busy <= 1'b0;
          if (rx) begin
            r_state <= S_IDLE;
          end else begin
            r_state     <= S_BREAK;
            r_frame_err <= 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start bit counts
          if (rx) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_R_FIFO_EN
  localparam int unsigned P_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [P_W:0] FULL_CNT = (P_W+1)'(FIFO_DEPTH);

  logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [P_W-1:0]     r_wr_ptr;
  logic [P_W-1:0]     r_rd_ptr;
  logic [P_W:0]       r_count;
  logic               w_full;
  logic               w_wr;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && rx_ready;
  // When full, a write is only possible because the head leaves on the same edge
  assign w_wr   = w_push && (!w_full || w_pop);

  // Output FIFO: pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + P_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (P_W+1)'(1);
        2'b01:   r_count <= r_count - (P_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data  = r_mem[r_rd_ptr];
  assign rx_valid = (r_count != '0);
`else
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;

  assign w_pop = r_valid && rx_ready;

  // FIFO_DEPTH only configures the FIFO build
  if (FIFO_DEPTH == 0) begin : g_no_fifo
  end

  // Single holding register: replace on push+pop, drop and flag on push while full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_push) begin
        if (!r_valid || w_pop) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
`endif

  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: frames are built from bytes, outputs are
// sampled #1 after the active edge, handshakes and pulses logged on the falling edge.
module tb_uart_receive;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int n_tests;
  int n_fail;
  int ov_cnt;
  int fe_cnt;
  logic [7:0] rxq[$];

  uart_receive #(.D_WIDTH(8), .C_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log consumed bytes and pulse counts; ready/valid are stable here until the next edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (overrun) ov_cnt++;
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pop_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pop_at_stop) rx_ready = 1'b1;
    send_bit(stop_b);
    if (pop_at_stop) rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    n_tests++; if ({frame_err, overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {frame_err, overrun}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single;
    int qb;
    logic [7:0] d;
    d = 8'h4A;
    qb = rxq.size();
    rx_ready = 1'b1;
    send_bit(1'b0);
    n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_start: got %b expected 1", rx_busy); end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b expected 0", rx_valid); end
    send_bit(1'b1);
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
    n_tests++; if (rx_data !== 8'h4A) begin n_fail++; $display("FAIL single_data: got %h expected 4a", rx_data); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", rx_busy); end
    idle(1);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_one_cycle: got %b expected 0", rx_valid); end
    n_tests++;
    if (rxq.size() - qb !== 1 || rxq[qb] !== 8'h4A) begin
      n_fail++; $display("FAIL single_received: got %0d bytes expected 1 (4a)", rxq.size() - qb);
    end
  endtask

  task automatic test_overrun;
    int qb, ob;
    qb = rxq.size(); ob = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h3C, 1'b1, 1'b0);
`ifdef UART_R_FIFO_EN
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 0", overrun); end
    idle(1);
    n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ovr_head: got %h expected a5", rx_data); end
    rx_ready = 1'b1;
    idle(3);
    n_tests++;
    if (rxq.size() - qb !== 2 || rxq[qb] !== 8'hA5 || rxq[qb+1] !== 8'h3C) begin
      n_fail++; $display("FAIL ovr_fifo_order: got %0d bytes expected 2 (a5,3c)", rxq.size() - qb);
    end
`else
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", overrun); end
    idle(1);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_clear: got %b expected 0", overrun); end
    n_tests++; if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL ovr_held: got %b/%h expected 1/a5", rx_valid, rx_data); end
    rx_ready = 1'b1;
    idle(3);
    n_tests++;
    if (rxq.size() - qb !== 1 || rxq[qb] !== 8'hA5) begin
      n_fail++; $display("FAIL ovr_kept: got %0d bytes expected 1 (a5)", rxq.size() - qb);
    end
`endif
    n_tests++;
`ifdef UART_R_FIFO_EN
    if (ov_cnt - ob !== 0) begin n_fail++; $display("FAIL ovr_count: got %0d expected 0", ov_cnt - ob); end
`else
    if (ov_cnt - ob !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt - ob); end
`endif
  endtask

  task automatic test_frame_err;
    int qb, fb;
    qb = rxq.size(); fb = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b0);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %b expected 1", frame_err); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    send_bit(1'b0);
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_not_sticky: got %b expected 0", frame_err); end
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    n_tests++; if ({rx_busy, rx_valid} !== 2'b00) begin n_fail++; $display("FAIL ferr_break_idle: got %b expected 00", {rx_busy, rx_valid}); end
    idle(1);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (rxq.size() - qb !== 1 || rxq[qb] !== 8'h11 || fe_cnt - fb !== 1) begin
      n_fail++; $display("FAIL ferr_recover: got %0d bytes, %0d errs expected 1 (11), 1", rxq.size() - qb, fe_cnt - fb);
    end
  endtask

  task automatic test_reset_mid;
    int qb;
    logic [7:0] d;
    d = 8'h77;
    qb = rxq.size();
    rx_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rx_valid, rx_busy, frame_err, overrun, rx_data} !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b%b%b%b/%h expected 0000/00", rx_valid, rx_busy, frame_err, overrun, rx_data);
    end
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (rxq.size() - qb !== 1 || rxq[qb] !== 8'h12) begin
      n_fail++; $display("FAIL rst_mid_recover: got %0d bytes expected 1 (12)", rxq.size() - qb);
    end
  endtask

  task automatic test_back_to_back;
    int qb, ob;
    qb = rxq.size(); ob = ov_cnt;
    rx_ready = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (rxq.size() - qb !== 2 || rxq[qb] !== 8'h01 || rxq[qb+1] !== 8'h80) begin
      n_fail++; $display("FAIL b2b_order: got %0d bytes expected 2 (01,80)", rxq.size() - qb);
    end
    n_tests++; if (ov_cnt - ob !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt - ob); end
  endtask

`ifdef UART_R_FIFO_EN
  task automatic test_fifo_full;
    int qb, ob;
    logic [7:0] exp [5];
    qb = rxq.size(); ob = ov_cnt;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
    n_tests++; if (ov_cnt - ob !== 1) begin n_fail++; $display("FAIL fifo_overrun_5th: got %0d expected 1", ov_cnt - ob); end
    n_tests++; if ({rx_valid, rx_data} !== {1'b1, 8'h10}) begin n_fail++; $display("FAIL fifo_head: got %b/%h expected 1/10", rx_valid, rx_data); end
    send_frame(8'h15, 1'b1, 1'b1);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fifo_pushpop_full: got %b expected 0", overrun); end
    rx_ready = 1'b1;
    idle(6);
    exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12; exp[3] = 8'h13; exp[4] = 8'h15;
    n_tests++;
    if (rxq.size() - qb !== 5) begin
      n_fail++; $display("FAIL fifo_drain_count: got %0d expected 5", rxq.size() - qb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rxq[qb+i] !== exp[i]) begin
          n_fail++; $display("FAIL fifo_drain_%0d: got %h expected %h", i, rxq[qb+i], exp[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; ov_cnt = 0; fe_cnt = 0;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    test_reset;
    test_single;
    test_overrun;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
`ifdef UART_R_FIFO_EN
    test_fifo_full;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
